// File: rtl/mips_writeback_queue.sv
// mips_writeback_queue: ordered writeback FIFO feeding the two write ports of
// the MIPS register file. It accepts up to two requests per cycle (mem is older
// than alu) and drains up to two entries per cycle into registered port outputs.
// Optional forwarding lookups are built when MIPS_WB_FORWARD_EN is defined.
// Otherwise the lookup outputs are tied to zero.
module mips_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_reg,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_reg,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   in_ready,
    output logic                   signal_reg_write_1,
    output logic [ADDR_W-1:0]      write_reg_1,
    output logic [DATA_W-1:0]      write_data_1,
    output logic                   signal_reg_write_2,
    output logic [ADDR_W-1:0]      write_reg_2,
    output logic [DATA_W-1:0]      write_data_2,
    input  logic [ADDR_W-1:0]      lookup_reg_a,
    output logic                   lookup_hit_a,
    output logic [DATA_W-1:0]      lookup_data_a,
    input  logic [ADDR_W-1:0]      lookup_reg_b,
    output logic                   lookup_hit_b,
    output logic [DATA_W-1:0]      lookup_data_b,
    output logic [$clog2(DEPTH):0] pending_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic              r_we1;
    logic [ADDR_W-1:0] r_wr1;
    logic [DATA_W-1:0] r_wd1;
    logic              r_we2;
    logic [ADDR_W-1:0] r_wr2;
    logic [DATA_W-1:0] r_wd2;

    logic              w_in_ready;
    logic              w_push_mem;
    logic              w_push_alu;
    logic              w_pop1;
    logic              w_pop2;
    logic [1:0]        w_npush;
    logic [1:0]        w_npop;
    logic [PW-1:0]     w_head1;
    logic [PW-1:0]     w_alu_slot;
    logic [DEPTH-1:0]  w_vld_next;

    // Room for both producers is judged from the registered count only.
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));

    // Writes to register 0 are architecturally void and never take a slot.
    assign w_push_mem = w_in_ready && mem_valid && (mem_reg != '0);
    assign w_push_alu = w_in_ready && alu_valid && (alu_reg != '0);
    assign w_alu_slot = r_tail + PW'(w_push_mem);
    assign w_npush    = {1'b0, w_push_mem} + {1'b0, w_push_alu};

    // A second pop is allowed only when the two oldest entries target
    // different registers, so each register keeps its commit order.
    assign w_head1 = r_head + PW'(1);
    assign w_pop1  = r_vld[r_head];
    assign w_pop2  = r_vld[r_head] && r_vld[w_head1] && (r_reg[r_head] != r_reg[w_head1]);
    assign w_npop  = {1'b0, w_pop1} + {1'b0, w_pop2};

    // Next valid bits: retire popped slots, then claim pushed slots.
    always_comb begin
        w_vld_next = r_vld;
        if (w_pop1)     w_vld_next[r_head]     = 1'b0;
        if (w_pop2)     w_vld_next[w_head1]    = 1'b0;
        if (w_push_mem) w_vld_next[r_tail]     = 1'b1;
        if (w_push_alu) w_vld_next[w_alu_slot] = 1'b1;
    end

    // Queue control: occupancy, pointers and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_vld   <= '0;
        end else begin
            r_count <= r_count + CW'(w_npush) - CW'(w_npop);
            r_head  <= r_head + PW'(w_npop);
            r_tail  <= r_tail + PW'(w_npush);
            r_vld   <= w_vld_next;
        end
    end

    // Entry payload storage; the valid bits decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (w_push_mem) begin
            r_reg[r_tail]  <= mem_reg;
            r_data[r_tail] <= mem_data;
        end
        if (w_push_alu) begin
            r_reg[w_alu_slot]  <= alu_reg;
            r_data[w_alu_slot] <= alu_data;
        end
    end

    // Write-port registers: load the popped entries and hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we1 <= 1'b0;
            r_wr1 <= '0;
            r_wd1 <= '0;
            r_we2 <= 1'b0;
            r_wr2 <= '0;
            r_wd2 <= '0;
        end else begin
            r_we1 <= w_pop1;
            r_we2 <= w_pop2;
            if (w_pop1) begin
                r_wr1 <= r_reg[r_head];
                r_wd1 <= r_data[r_head];
            end
            if (w_pop2) begin
                r_wr2 <= r_reg[w_head1];
                r_wd2 <= r_data[w_head1];
            end
        end
    end

    assign in_ready           = w_in_ready;
    assign pending_count      = r_count;
    assign signal_reg_write_1 = r_we1;
    assign write_reg_1        = r_wr1;
    assign write_data_1       = r_wd1;
    assign signal_reg_write_2 = r_we2;
    assign write_reg_2        = r_wr2;
    assign write_data_2       = r_wd2;

`ifdef MIPS_WB_FORWARD_EN
    // Priority from lowest to highest: port 1, port 2, then the queue from
    // oldest to youngest, so the youngest pending value wins.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] q);
        logic [DATA_W:0] res;
        logic [PW-1:0]   idx;
        res = '0;
        if (r_we1 && (r_wr1 == q)) res = {1'b1, r_wd1};
        if (r_we2 && (r_wr2 == q)) res = {1'b1, r_wd2};
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + PW'(k);
            if (r_vld[idx] && (r_reg[idx] == q)) res = {1'b1, r_data[idx]};
        end
        if (q == '0) res = '0;
        return res;
    endfunction

    assign {lookup_hit_a, lookup_data_a} = fwd_lookup(lookup_reg_a);
    assign {lookup_hit_b, lookup_data_b} = fwd_lookup(lookup_reg_b);
`else
    logic w_unused_lookup;

    assign lookup_hit_a    = 1'b0;
    assign lookup_data_a   = '0;
    assign lookup_hit_b    = 1'b0;
    assign lookup_data_b   = '0;
    assign w_unused_lookup = ^{lookup_reg_a, lookup_reg_b};
`endif

endmodule
